// File: rtl/fetch_queue.sv
// Fetch queue: issues in-order instruction fetches and buffers
// returned words until Decode accepts them; flushes on redirect.
module fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  input  logic                     deq_ready,
  output logic                     deq_valid,
  output logic [31:0]              InstrD,
  output logic [XLEN-1:0]          PCD,
  output logic [XLEN-1:0]          PCPlus4D,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   head;
  logic [CW-1:0]   tail;
  logic [CW-1:0]   fptr;
  logic [CW-1:0]   drop_cnt;
  logic [DEPTH-1:0] filled;
  logic            run;

  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [31:0]     ins_mem [DEPTH];

  logic [CW-1:0]   pend;
  logic [CW:0]     used;
  logic [CW-1:0]   redir_drop;
  logic [AW-1:0]   h_idx;
  logic [AW-1:0]   t_idx;
  logic [AW-1:0]   f_idx;
  logic            head_full;
  logic            req_hs;
  logic            pop;
  logic            rsp_drop;
  logic            rsp_fill;
  logic            rsp_bad;

  assign h_idx = head[AW-1:0];
  assign t_idx = tail[AW-1:0];
  assign f_idx = fptr[AW-1:0];

  assign count = tail - head;
  assign pend  = tail - fptr;
  assign used  = {1'b0, count} + {1'b0, drop_cnt};

  // run keeps requests off until the first edge after reset release
  assign imem_req_valid = run & ~redirect_valid & (used < FULL);
  assign imem_req_addr  = fetch_pc;
  assign req_hs = imem_req_valid & imem_req_ready;

  assign head_full = filled[h_idx];
  assign deq_valid = head_full & ~redirect_valid;
  assign pop       = deq_valid & deq_ready;

  // responses retire dropped fetches first, since memory is in order
  assign rsp_drop = imem_rsp_valid & (drop_cnt != '0);
  assign rsp_fill = imem_rsp_valid & (drop_cnt == '0) & (pend != '0);
  assign rsp_bad  = imem_rsp_valid & (drop_cnt == '0) & (pend == '0);

  assign redir_drop = drop_cnt + pend
                    - CW'(rsp_drop | rsp_fill);

  // an empty head reads as zero so reset clears the decode view
  assign InstrD   = head_full ? ins_mem[h_idx] : '0;
  assign PCD      = head_full ? pc_mem[h_idx] : '0;
  assign PCPlus4D = head_full ? pc_mem[h_idx] + XLEN'(4) : '0;

  // control state: pointers, fill flags, drop count, error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run      <= 1'b0;
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      fptr     <= '0;
      drop_cnt <= '0;
      filled   <= '0;
      rsp_err  <= 1'b0;
    end else begin
      run <= 1'b1;
      if (rsp_bad)
        rsp_err <= 1'b1;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        head     <= '0;
        tail     <= '0;
        fptr     <= '0;
        filled   <= '0;
        drop_cnt <= redir_drop;
      end else begin
        if (req_hs) begin
          tail     <= tail + CW'(1);
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (rsp_drop)
          drop_cnt <= drop_cnt - CW'(1);
        if (rsp_fill) begin
          fptr          <= fptr + CW'(1);
          filled[f_idx] <= 1'b1;
        end
        if (pop) begin
          head          <= head + CW'(1);
          filled[h_idx] <= 1'b0;
        end
      end
    end
  end

  // entry payload; validity is carried by the filled flags
  always_ff @(posedge clk) begin
    if (req_hs)
      pc_mem[t_idx] <= fetch_pc;
    if (rsp_fill && !redirect_valid)
      ins_mem[f_idx] <= imem_rsp_data;
  end

endmodule
